// File: rtl/student_tlul_socket_1n.sv
// TL-UL 1-to-NUM socket: address decode, in-order outstanding tracking and an
// error responder for unmapped addresses. Carries its own minimal tlul_pkg.
package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
endpackage

module student_tlul_socket_1n #(
    parameter int NUM    = 2,
    parameter int MaxOut = 4,
    // The default map covers two devices; override both maps when changing NUM.
    parameter logic [NUM-1:0][31:0] BASE_ADDR = {32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM-1:0][31:0] ADDR_MASK = {NUM{32'hFFFF_F000}}
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  tlul_pkg::tl_h2d_t             tl_i,
    output tlul_pkg::tl_d2h_t             tl_o,
    input  tlul_pkg::tl_d2h_t [NUM-1:0]   children_o,
    output tlul_pkg::tl_h2d_t [NUM-1:0]   children_i
);
    import tlul_pkg::*;

    localparam int CW = $clog2(MaxOut + 1);
    localparam int SW = $clog2(NUM + 1);
    localparam logic [SW-1:0] ERR_SEL = SW'(NUM);

    logic [CW-1:0] cnt_reg;
    logic [SW-1:0] dev_sel_reg;
    logic          err_vld_reg;
    logic [7:0]    err_src_reg;
    logic [2:0]    err_op_reg;

    logic [SW-1:0] dec;
    logic          idle, full, stall;
    logic          dev_a_ready;
    logic          a_hs, d_hs;
    tl_d2h_t       err_rsp, sel_rsp;

    // Lowest-index match wins, so iterate downwards and let later hits override.
    always_comb begin
        dec = ERR_SEL;
        for (int i = NUM - 1; i >= 0; i--) begin
            if ((tl_i.a_address & ADDR_MASK[i]) == BASE_ADDR[i]) begin
                dec = SW'(i);
            end
        end
    end

    assign idle  = (cnt_reg == '0);
    assign full  = (cnt_reg == CW'(MaxOut));
    assign stall = rst_i | full | (!idle && (dec != dev_sel_reg));

    always_comb begin
        dev_a_ready = !err_vld_reg;
        for (int i = 0; i < NUM; i++) begin
            if (dec == SW'(i)) begin
                dev_a_ready = children_o[i].a_ready;
            end
        end
    end

    for (genvar gi = 0; gi < NUM; gi++) begin : g_child
        tl_h2d_t req;
        always_comb begin
            req         = tl_i;
            req.a_valid = tl_i.a_valid & (dec == SW'(gi)) & !stall;
            req.d_ready = tl_i.d_ready & !idle & (dev_sel_reg == SW'(gi));
        end
        assign children_i[gi] = req;
    end

    always_comb begin
        err_rsp          = '0;
        err_rsp.d_valid  = err_vld_reg;
        err_rsp.d_opcode = (err_op_reg == Get) ? AccessAckData : AccessAck;
        err_rsp.d_source = err_src_reg;
        err_rsp.d_data   = 32'hFFFF_FFFF;
        err_rsp.d_error  = 1'b1;
        sel_rsp = err_rsp;
        for (int i = 0; i < NUM; i++) begin
            if (dev_sel_reg == SW'(i)) begin
                sel_rsp = children_o[i];
            end
        end
        tl_o = sel_rsp;
        if (idle) begin
            tl_o.d_valid = 1'b0;
        end
        tl_o.a_ready = !stall & dev_a_ready;
    end

    assign a_hs = tl_i.a_valid & tl_o.a_ready;
    assign d_hs = tl_o.d_valid & tl_i.d_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_reg     <= '0;
            dev_sel_reg <= '0;
            err_vld_reg <= 1'b0;
            err_src_reg <= '0;
            err_op_reg  <= '0;
        end else begin
            if (a_hs) begin
                dev_sel_reg <= dec;
            end
            case ({a_hs, d_hs})
                2'b10:   cnt_reg <= cnt_reg + 1'b1;
                2'b01:   cnt_reg <= cnt_reg - 1'b1;
                default: cnt_reg <= cnt_reg;
            endcase
            if (d_hs && dev_sel_reg == ERR_SEL) begin
                err_vld_reg <= 1'b0;
            end
            if (a_hs && dec == ERR_SEL) begin
                err_vld_reg <= 1'b1;
                err_src_reg <= tl_i.a_source;
                err_op_reg  <= tl_i.a_opcode;
            end
        end
    end
endmodule

// File: tb/tb_student_tlul_socket_1n.sv
// Bench for student_tlul_socket_1n: two queued device models, a response
// scoreboard on the host port, and directed checks of stall/error behaviour.
module tb_student_tlul_socket_1n;
    import tlul_pkg::*;

    logic                clk;
    logic                rst;
    tl_h2d_t             host;
    tl_d2h_t             host_rsp;
    tl_d2h_t [1:0]       dev_rsp;
    tl_h2d_t [1:0]       dev_req;
    logic [1:0]          dev_a_ready;
    logic [1:0]          resp_en;

    int n_checks = 0;
    int n_pass   = 0;
    int n_resp   = 0;
    logic [63:0] sb[$];

    student_tlul_socket_1n dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .tl_i       (host),
        .tl_o       (host_rsp),
        .children_o (dev_rsp),
        .children_i (dev_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("check %-16s ok   value=%0h", tag, obs);
        end else begin
            $display("FAIL %-16s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dev_data(input int i, input logic [31:0] addr, input logic [7:0] src);
        if (addr == 32'h0000_1004) return 32'h0000_CAFE;
        return {8'hD0 + 8'(i), addr[15:0], src};
    endfunction

    // Expected host-side response packed as {error, opcode, source, data}.
    function automatic logic [63:0] expect_rsp(input logic [31:0] addr, input logic [2:0] op, input logic [7:0] src);
        logic [2:0] dop;
        dop = (op == Get) ? 3'h1 : 3'h0;
        if (addr[31:12] == 20'h0) return {20'h0, 1'b0, dop, src, dev_data(0, addr, src)};
        if (addr[31:12] == 20'h1) return {20'h0, 1'b0, dop, src, dev_data(1, addr, src)};
        return {20'h0, 1'b1, dop, src, 32'hFFFF_FFFF};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dev
        logic [63:0] q[$];
        int          qn;
        logic [63:0] front;
        tl_d2h_t     rsp;
        always @(posedge clk) begin
            if (rst) begin
                q.delete();
            end else begin
                if (dev_rsp[gi].d_valid && dev_req[gi].d_ready) void'(q.pop_front());
                if (dev_req[gi].a_valid && dev_a_ready[gi])
                    q.push_back({20'h0, 1'b0, (dev_req[gi].a_opcode == Get) ? 3'h1 : 3'h0,
                                 dev_req[gi].a_source,
                                 dev_data(gi, dev_req[gi].a_address, dev_req[gi].a_source)});
            end
            qn    <= rst ? 0 : q.size();
            front <= (!rst && q.size() != 0) ? q[0] : 64'h0;
        end
        always_comb begin
            rsp          = '0;
            rsp.d_valid  = (qn != 0) && resp_en[gi];
            rsp.d_opcode = front[42:40];
            rsp.d_source = front[39:32];
            rsp.d_data   = front[31:0];
            rsp.d_error  = front[43];
            rsp.a_ready  = dev_a_ready[gi];
        end
        assign dev_rsp[gi] = rsp;
    end

    // Scoreboard: push on A handshake, pop and compare on D handshake.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (host_rsp.d_valid && host.d_ready) begin
                if (sb.size() == 0) begin
                    check_eq("d_unexpected", 64'h1, 64'h0);
                end else begin
                    check_eq("d_resp", {20'h0, host_rsp.d_error, host_rsp.d_opcode,
                                        host_rsp.d_source, host_rsp.d_data}, sb.pop_front());
                    n_resp++;
                end
            end
            if (host.a_valid && host_rsp.a_ready)
                sb.push_back(expect_rsp(host.a_address, host.a_opcode, host.a_source));
        end
    end

    task automatic send(input logic [31:0] addr, input logic [2:0] op, input logic [7:0] src);
        host.a_valid   = 1'b1;
        host.a_address = addr;
        host.a_opcode  = op;
        host.a_source  = src;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (host_rsp.a_ready) begin
                @(posedge clk);
                #1;
                host.a_valid = 1'b0;
                return;
            end
        end
        check_eq("a_timeout", 64'h0, 64'h1);
        host.a_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dut.cnt_reg == '0) return;
        end
        check_eq("drain_timeout", 64'h0, 64'h1);
    endtask

    initial begin
        host           = '0;
        host.d_ready   = 1'b1;
        dev_a_ready    = 2'b11;
        resp_en        = 2'b11;
        rst            = 1'b1;
        host.a_valid   = 1'b1;
        host.a_address = 32'h0000_1004;
        host.a_opcode  = Get;

        // Reset held with a request pending
        @(negedge clk);
        check_eq("rst_ch0_avalid", 64'(dev_req[0].a_valid), 64'h0);
        check_eq("rst_ch1_avalid", 64'(dev_req[1].a_valid), 64'h0);
        check_eq("rst_dvalid", 64'(host_rsp.d_valid), 64'h0);
        @(negedge clk);
        check_eq("rst_ch1_avalid2", 64'(dev_req[1].a_valid), 64'h0);
        @(posedge clk); #1;
        rst          = 1'b0;
        host.a_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_cnt", 64'(dut.cnt_reg), 64'h0);

        // Single Get to device 1
        @(posedge clk); #1;
        host.a_valid = 1'b1; host.a_address = 32'h0000_1004; host.a_source = 8'd1;
        @(negedge clk);
        check_eq("get1_ch0_avalid", 64'(dev_req[0].a_valid), 64'h0);
        check_eq("get1_ch1_avalid", 64'(dev_req[1].a_valid), 64'h1);
        @(posedge clk); #1;
        host.a_valid = 1'b0;
        @(negedge clk);
        check_eq("get1_cnt1", 64'(dut.cnt_reg), 64'h1);
        check_eq("get1_data", 64'(host_rsp.d_data), 64'h0000_CAFE);
        check_eq("get1_derr", 64'(host_rsp.d_error), 64'h0);
        @(negedge clk);
        check_eq("get1_cnt0", 64'(dut.cnt_reg), 64'h0);

        // Fill to MaxOut, fifth request waits for one response
        @(posedge clk); #1;
        resp_en[0] = 1'b0;
        for (int k = 0; k < 4; k++) send(32'h10 * k, Get, 8'(k));
        host.a_valid = 1'b1; host.a_address = 32'h40; host.a_source = 8'd4;
        @(negedge clk);
        check_eq("full_aready", 64'(host_rsp.a_ready), 64'h0);
        check_eq("full_cnt", 64'(dut.cnt_reg), 64'h4);
        resp_en[0] = 1'b1;
        @(posedge clk); #1;
        resp_en[0] = 1'b0;
        @(negedge clk);
        check_eq("full_cnt3", 64'(dut.cnt_reg), 64'h3);
        check_eq("full_aready2", 64'(host_rsp.a_ready), 64'h1);
        @(posedge clk); #1;
        host.a_valid = 1'b0;
        resp_en[0] = 1'b1;
        wait_idle();

        // Switching target waits for the previous device to drain
        @(posedge clk); #1;
        resp_en[0] = 1'b0;
        send(32'h0000_0008, Get, 8'd5);
        host.a_valid = 1'b1; host.a_address = 32'h0000_1008; host.a_source = 8'd6;
        @(negedge clk);
        check_eq("switch_aready", 64'(host_rsp.a_ready), 64'h0);
        check_eq("switch_ch1_av", 64'(dev_req[1].a_valid), 64'h0);
        @(negedge clk);
        check_eq("switch_aready2", 64'(host_rsp.a_ready), 64'h0);
        resp_en[0] = 1'b1;
        @(negedge clk);
        check_eq("switch_accept", 64'(host_rsp.a_ready), 64'h1);
        @(posedge clk); #1;
        host.a_valid = 1'b0;
        wait_idle();

        // Unmapped Get, response held while d_ready is low
        @(posedge clk); #1;
        host.d_ready = 1'b0;
        send(32'h8000_0000, Get, 8'd3);
        @(negedge clk);
        check_eq("err_dvalid", 64'(host_rsp.d_valid), 64'h1);
        check_eq("err_derror", 64'(host_rsp.d_error), 64'h1);
        check_eq("err_dsource", 64'(host_rsp.d_source), 64'h3);
        check_eq("err_dopcode", 64'(host_rsp.d_opcode), 64'(AccessAckData));
        check_eq("err_ddata", 64'(host_rsp.d_data), 64'hFFFF_FFFF);
        @(posedge clk); #1;
        host.a_valid = 1'b1; host.a_address = 32'h8000_0004;
        host.a_opcode = PutFullData; host.a_source = 8'd9;
        @(negedge clk);
        check_eq("err_hold_valid", 64'(host_rsp.d_valid), 64'h1);
        check_eq("err_hold_src", 64'(host_rsp.d_source), 64'h3);
        check_eq("err_cap1_aready", 64'(host_rsp.a_ready), 64'h0);
        host.d_ready = 1'b1;
        @(negedge clk);
        check_eq("err2_aready", 64'(host_rsp.a_ready), 64'h1);
        @(posedge clk); #1;
        host.a_valid = 1'b0; host.a_opcode = Get;
        @(negedge clk);
        check_eq("err2_dopcode", 64'(host_rsp.d_opcode), 64'(AccessAck));
        wait_idle();

        // Simultaneous A and D handshake, then reset mid-burst
        @(posedge clk); #1;
        resp_en[0] = 1'b0;
        send(32'h0, Get, 8'd10);
        send(32'h4, Get, 8'd11);
        host.a_valid = 1'b1; host.a_address = 32'hC; host.a_source = 8'd12;
        resp_en[0] = 1'b1;
        @(negedge clk);
        check_eq("simul_pre_cnt", 64'(dut.cnt_reg), 64'h2);
        check_eq("simul_aready", 64'(host_rsp.a_ready), 64'h1);
        check_eq("simul_dvalid", 64'(host_rsp.d_valid), 64'h1);
        @(posedge clk); #1;
        host.a_valid = 1'b0;
        resp_en[0] = 1'b0;
        @(negedge clk);
        check_eq("simul_cnt", 64'(dut.cnt_reg), 64'h2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        resp_en[0] = 1'b1;
        @(negedge clk);
        check_eq("midrst_cnt", 64'(dut.cnt_reg), 64'h0);
        check_eq("midrst_dvalid", 64'(host_rsp.d_valid), 64'h0);
        repeat (3) @(negedge clk);
        check_eq("midrst_dvalid2", 64'(host_rsp.d_valid), 64'h0);

        check_eq("sb_empty", 64'(sb.size()), 64'h0);
        check_eq("resp_count", 64'(n_resp), 64'd11);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
